// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle RV64M multiply/divide unit sitting beside EX.
//               Radix-2 shift-add multiply and restoring divide on operand
//               magnitudes, one iteration per clock, followed by a single
//               sign-fix cycle. Results are held until the next operation.
// Ports       : clk           - clock, rising edge
//               rst           - asynchronous reset, active low
//               flush_i       - abort any in-flight operation
//               req_valid_i   - request present
//               req_ready_o   - unit idle and able to accept
//               mul_en_i      - 1 = multiply, 0 = divide/remainder
//               rs1_data_i    - multiplicand / dividend
//               rs2_data_i    - multiplier / divisor
//               rs1_sign_i    - treat rs1 as signed
//               rs2_sign_i    - treat rs2 as signed
//               resp_valid_o  - one-cycle result strobe
//               data_1_o      - product[XLEN-1:0] or quotient
//               data_2_o      - product[2*XLEN-1:XLEN] or remainder
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            mul_en_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            rs1_sign_i,
    input  logic            rs2_sign_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] data_1_o,
    output logic [XLEN-1:0] data_2_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                mul_q,   mul_d;
    logic                negq_q,  negq_d;   // negate quotient / product
    logic                negr_q,  negr_d;   // negate remainder
    // Multiply: |rs1| (added into the high half). Divide: |rs2| (divisor).
    logic [XLEN-1:0]     opnd_q,  opnd_d;
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide  : {remainder, dividend shifting out / quotient shifting in}.
    logic [2*XLEN-1:0]   acc_q,   acc_d;
    logic [XLEN-1:0]     d1_q,    d1_d;
    logic [XLEN-1:0]     d2_q,    d2_d;

    logic                rs1_neg, rs2_neg;
    logic [XLEN-1:0]     rs1_mag, rs2_mag;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_sh;
    logic [XLEN:0]       div_diff;
    logic                div_ok;
    logic [2*XLEN-1:0]   mul_next, div_next;
    logic [2*XLEN-1:0]   acc_neg;

    // Magnitudes: the unsigned negate of -2^(XLEN-1) is itself, which is the
    // correct unsigned magnitude.
    assign rs1_neg = rs1_sign_i & rs1_data_i[XLEN-1];
    assign rs2_neg = rs2_sign_i & rs2_data_i[XLEN-1];
    assign rs1_mag = rs1_neg ? ('0 - rs1_data_i) : rs1_data_i;
    assign rs2_mag = rs2_neg ? ('0 - rs2_data_i) : rs2_data_i;

    // Shift-add step: the sum keeps its carry as the new top bit while the
    // whole accumulator shifts right by one.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring step: the shifted remainder needs XLEN+1 bits because the
    // divisor may use the full XLEN range; bit XLEN of the difference is the
    // borrow.
    assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_ok   = ~div_diff[XLEN];
    assign div_next = {(div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                       acc_q[XLEN-2:0], div_ok};

    assign acc_neg  = '0 - acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        d1_d    = d1_q;
        d2_d    = d2_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    mul_d  = mul_en_i;
                    negq_d = rs1_neg ^ rs2_neg;
                    negr_d = rs1_neg;
                    cnt_d  = '0;
                    if (mul_en_i) begin
                        opnd_d  = rs1_mag;
                        acc_d   = {{XLEN{1'b0}}, rs2_mag};
                        state_d = S_CALC;
                    end else if (rs2_data_i == '0) begin
                        d1_d    = '1;
                        d2_d    = rs1_data_i;
                        state_d = S_DONE;
                    end else begin
                        opnd_d  = rs2_mag;
                        acc_d   = {{XLEN{1'b0}}, rs1_mag};
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = mul_q ? mul_next : div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (mul_q) begin
                    d1_d = negq_q ? acc_neg[XLEN-1:0]      : acc_q[XLEN-1:0];
                    d2_d = negq_q ? acc_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
                end else begin
                    d1_d = negq_q ? ('0 - acc_q[XLEN-1:0])      : acc_q[XLEN-1:0];
                    d2_d = negr_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush beats both accept and completion; results stay untouched.
        if (flush_i) begin
            state_d = S_IDLE;
            d1_d    = d1_q;
            d2_d    = d2_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_DONE);
    assign data_1_o     = d1_q;
    assign data_2_o     = d2_q;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide responder that sits beside the EX stage.
- Executes RV64M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. The W forms arrive from EX with operands already 32→64 extended, and EX truncates/extends the results.
- Accepts a request over a valid/ready handshake and returns two 64-bit results (low/quotient, high/remainder) with a one-cycle response strobe. The pipeline stalls EX while the unit is busy.

Parameters:
- XLEN, 64, operand/result width.
- CNT_W, 6, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush_i  in  1  abort any in-flight operation (branch/exception flush)
- req_valid_i  in  1  request present (from EX muldiv_req_valid)
- req_ready_o  out  1  unit can accept a request
- mul_en_i  in  1  1 = multiply, 0 = divide/remainder
- rs1_data_i  in  XLEN  multiplicand / dividend
- rs2_data_i  in  XLEN  multiplier / divisor
- rs1_sign_i  in  1  1 = treat rs1 as signed
- rs2_sign_i  in  1  1 = treat rs2 as signed
- resp_valid_o  out  1  one-cycle strobe: results valid
- data_1_o  out  XLEN  product[63:0] or quotient
- data_2_o  out  XLEN  product[127:64] or remainder

Behaviour:
- Reset (rst=0, async): state=IDLE; counter, accumulators, data_1_o, data_2_o = 0; resp_valid_o=0; req_ready_o=1.
- req_ready_o = (state==IDLE). Accept on a rising edge with req_valid_i && req_ready_o && !flush_i. req_valid_i in any other state is ignored; EX holds the request until resp_valid_o.
- States: IDLE, CALC, FIX, DONE.
- On accept:
  - Latch mode.
  - Latch operand magnitudes: |x| if sign flag set and x[63]=1, else x. The magnitude of -2^63 is 2^63 (unsigned).
  - Latch neg_q/neg_p = (rs1_sign&rs1[63]) ^ (rs2_sign&rs2[63]) and neg_r = rs1_sign&rs1[63].
  - Set counter=0 and go to CALC.
- Divide with rs2_data_i==0: go directly to DONE instead of CALC. Load data_1_o=all ones (unsigned quotient all ones, which is also -1 signed) and data_2_o=rs1_data_i unchanged.
- CALC: one iteration per cycle, counter increments; when counter==XLEN-1 the next state is FIX (XLEN iterations).
  - Multiply: radix-2 shift-add into a 128-bit accumulator.
  - Divide: restoring; shift {rem,quot} left 1, trial-subtract the divisor, set the quotient bit if there is no borrow.
- FIX: apply sign correction, register into data_1_o/data_2_o, go to DONE.
  - Multiply: 128-bit two's complement negate if neg_p.
  - Divide: quotient negated if neg_q; remainder negated if neg_r.
- DONE: resp_valid_o=1 for exactly this cycle, then IDLE. No accept is possible in DONE.
- Latency: resp_valid_o is high in the cycle following the 66th rising edge after the accepting edge (accept + 64 CALC + FIX). Divide-by-zero responds in the cycle after the accepting edge.
- data_1_o/data_2_o hold their values from FIX/DONE until overwritten by the next operation's FIX/div-by-zero load.
- Signed overflow (-2^63 / -1) needs no special case: quotient=0x8000_0000_0000_0000, remainder=0.
- Sign combinations: MULHSU = rs1_sign=1, rs2_sign=0; unsigned ops have both flags 0. The unit trusts the flags and does not decode funct3.
- flush_i=1 in any state: the next state is IDLE, no resp_valid_o is issued, and outputs keep their previous values. flush_i has priority over accept and over completion.
- Reset mid-operation: immediate return to reset values; no response.

Test Plan:
- Signed mul: mul_en=1, rs1=3, rs2=0xFFFF_FFFF_FFFF_FFFB, both signs=1 → resp_valid exactly 66 edges after accept; data_1=0xFFFF_FFFF_FFFF_FFF1, data_2=0xFFFF_FFFF_FFFF_FFFF. req_ready=0 throughout.
- Unsigned mul high: rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2, signs=0 → data_1=0xFFFF_FFFF_FFFF_FFFE, data_2=1. MULHSU with rs1=-1, rs2=2, sign1=1, sign2=0 → data_2=0xFFFF_FFFF_FFFF_FFFF, data_1=0xFFFF_FFFF_FFFF_FFFE.
- Signed div: rs1=-7, rs2=2, signs=1 → data_1=0xFFFF_FFFF_FFFF_FFFD (-3), data_2=0xFFFF_FFFF_FFFF_FFFF (-1). Unsigned 100/7 → 14, 2.
- Divide by zero: rs1=0x1234, rs2=0, signed → resp_valid one cycle after accept; data_1=0xFFFF_FFFF_FFFF_FFFF, data_2=0x1234. Overflow: rs1=0x8000_0000_0000_0000, rs2=-1, signed → data_1=0x8000_0000_0000_0000, data_2=0.
- Flush/reset mid-op:
  - flush_i at CALC counter=20 → req_ready=1 next cycle, no resp_valid, data outputs unchanged; a new request is then accepted and completes correctly.
  - rst low at counter=40 → all outputs reset immediately (asynchronously).
- Back-to-back: req_valid held high across two requests → second accepted the edge after the DONE cycle; each response has exactly one resp_valid pulse; requests asserted while busy are never double-accepted.
